ifid_queue: RTL and testbench

Instruction queue between the fetch stage and decode: buffers up to DEPTH fetched IF_ID bundles (instruction, pc, pcplus4) in a circular FIFO. It decouples decode stalls (load-use, multi-cycle ops) from fetch by driving the fetch stage's PC-hold control. Its head entry is presented to decode with a valid flag. A branch or jump flush discards all queued entries in one cycle.

---
 rtl/my_112l_pkg.sv | 24 ++
 rtl/ifid_queue_storage.sv | 27 ++
 rtl/ifid_queue.sv | 79 +++++++
 tb/tb_ifid_queue.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/my_112l_pkg.sv
// Shared fetch/decode types: the IF_ID pipeline bundle plus instruction-queue constants.
package my_112l_pkg;

    localparam int IFQ_PC_W          = 9;
    localparam int IFQ_INS_W         = 32;
    localparam int IFQ_DEFAULT_DEPTH = 4;

    localparam logic [IFQ_INS_W-1:0] IFQ_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [IFQ_INS_W-1:0] instruction;
        logic [IFQ_PC_W-1:0]  pc;
        logic [IFQ_PC_W-1:0]  pcplus4;
    } IF_ID;

    function automatic IF_ID ifq_nop();
        IF_ID b;
        b.instruction = IFQ_NOP_INSTR;
        b.pc          = '0;
        b.pcplus4     = '0;
        return b;
    endfunction

endpackage

// File: rtl/ifid_queue_storage.sv
// ifq_storage: DEPTH x W flop array, one synchronous write port, one combinational read port.
module ifq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 50
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;

    // Contents are deliberately not reset; occupancy alone decides validity.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we && waddr == AW'(g))
                mem[g] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifid_queue.sv
// Fetch->decode instruction queue; optional stall/flush counters under IFQ_STATS_EN.
module ifid_queue
    import my_112l_pkg::*;
#(
    parameter int PC_W  = IFQ_PC_W,
    parameter int INS_W = IFQ_INS_W,
    parameter int DEPTH = IFQ_DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  IF_ID                   if_id_in,
    input  logic                   in_valid,
    input  logic                   id_ready,
    input  logic                   flush,
    output logic                   pc_write,
    output logic                   out_valid,
    output IF_ID                   if_id_out,
    output logic [$clog2(DEPTH):0] count
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [15:0]            flush_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = INS_W + 2 * PC_W;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [BW-1:0] rdata;

    // Handshake flags come from registered count only, never from inputs.
    assign pc_write  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & pc_write & ~flush;
    assign pop       = out_valid & id_ready & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    ifq_storage #(.DEPTH(DEPTH), .W(BW)) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (if_id_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign if_id_out = out_valid ? IF_ID'(rdata) : ifq_nop();

`ifdef IFQ_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (in_valid && !pc_write && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush && flush_count != '1)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifid_queue.sv
// Directed table-driven bench for ifid_queue; stats checks run when IFQ_STATS_EN is defined.
module tb_ifid_queue;
    import my_112l_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    IF_ID       if_id_in;
    logic       in_valid, id_ready, flush;
    logic       pc_write, out_valid;
    IF_ID       if_id_out;
    logic [2:0] count;
`ifdef IFQ_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ifid_queue #(.PC_W(9), .INS_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_id_in  (if_id_in),
        .in_valid  (in_valid),
        .id_ready  (id_ready),
        .flush     (flush),
        .pc_write  (pc_write),
        .out_valid (out_valid),
        .if_id_out (if_id_out),
        .count     (count)
`ifdef IFQ_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    typedef struct {
        logic       iv;
        logic       rdy;
        logic       fl;
        logic [8:0] pc;
        int         cnt;
        logic       ov;
        logic       pw;
        logic [8:0] opc;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] instr_of(logic [8:0] pc);
        return 32'hA000_0000 | 32'(pc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic rdy, input logic fl, input logic [8:0] pc);
        in_valid             = iv;
        id_ready             = rdy;
        flush                = fl;
        if_id_in.instruction = instr_of(pc);
        if_id_in.pc          = pc;
        if_id_in.pcplus4     = pc + 9'd4;
    endtask

    task automatic add(input logic iv, input logic rdy, input logic fl, input logic [8:0] pc,
                       input int cnt, input logic ov, input logic pw, input logic [8:0] opc);
        vec_t v;
        v.iv = iv; v.rdy = rdy; v.fl = fl; v.pc = pc;
        v.cnt = cnt; v.ov = ov; v.pw = pw; v.opc = opc;
        tv.push_back(v);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_pc_write"}, 32'(pc_write), 32'd1);
        chk({tag, "_nop_instr"}, if_id_out.instruction, 32'h0000_0013);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 9'd0);

        // streaming: one-cycle latency, count steady at 1
        add(1,1,0,9'h000, 1,1,1,9'h000);
        add(1,1,0,9'h004, 1,1,1,9'h004);
        add(1,1,0,9'h008, 1,1,1,9'h008);
        add(0,1,0,9'h000, 0,0,1,9'h000);
        // backpressure: 5th offer dropped while full
        add(1,0,0,9'h000, 1,1,1,9'h000);
        add(1,0,0,9'h004, 2,1,1,9'h000);
        add(1,0,0,9'h008, 3,1,1,9'h000);
        add(1,0,0,9'h00C, 4,1,0,9'h000);
        add(1,0,0,9'h010, 4,1,0,9'h000);
        add(0,1,0,9'h000, 3,1,1,9'h004);
        add(0,1,0,9'h000, 2,1,1,9'h008);
        add(0,1,0,9'h000, 1,1,1,9'h00C);
        add(0,1,0,9'h000, 0,0,1,9'h000);
        // wrap-around with alternating stalls
        add(1,0,0,9'h020, 1,1,1,9'h020);
        add(1,1,0,9'h024, 1,1,1,9'h024);
        add(1,0,0,9'h028, 2,1,1,9'h024);
        add(1,1,0,9'h02C, 2,1,1,9'h028);
        add(1,0,0,9'h030, 3,1,1,9'h028);
        add(1,1,0,9'h034, 3,1,1,9'h02C);
        add(0,1,0,9'h000, 2,1,1,9'h030);
        add(0,1,0,9'h000, 1,1,1,9'h034);
        add(0,0,0,9'h000, 1,1,1,9'h034);
        add(0,1,0,9'h000, 0,0,1,9'h000);
        // flush with count=3 and simultaneous push/pop requests
        add(1,0,0,9'h050, 1,1,1,9'h050);
        add(1,0,0,9'h054, 2,1,1,9'h050);
        add(1,0,0,9'h058, 3,1,1,9'h050);
        add(1,1,1,9'h05C, 0,0,1,9'h000);
        add(1,1,0,9'h040, 1,1,1,9'h040);
        add(0,1,0,9'h000, 0,0,1,9'h000);
        // full + pop: push blocked, then push/pop together
        add(1,0,0,9'h060, 1,1,1,9'h060);
        add(1,0,0,9'h064, 2,1,1,9'h060);
        add(1,0,0,9'h068, 3,1,1,9'h060);
        add(1,0,0,9'h06C, 4,1,0,9'h060);
        add(1,1,0,9'h070, 3,1,1,9'h064);
        add(1,1,0,9'h070, 3,1,1,9'h068);
        add(0,0,1,9'h000, 0,0,1,9'h000);

        #1;
        chk_idle("reset");
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_idle("post_release");

        foreach (tv[i]) begin
            drive(tv[i].iv, tv[i].rdy, tv[i].fl, tv[i].pc);
            @(posedge clk); #1;
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].cnt));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tv[i].ov));
            chk($sformatf("v%0d_pc_write", i), 32'(pc_write), 32'(tv[i].pw));
            chk($sformatf("v%0d_out_pc", i), 32'(if_id_out.pc), 32'(tv[i].opc));
            chk($sformatf("v%0d_out_instr", i), if_id_out.instruction,
                tv[i].ov ? instr_of(tv[i].opc) : 32'h0000_0013);
        end

        // asynchronous reset in the middle of a cycle with entries queued
        drive(1'b1, 1'b0, 1'b0, 9'h080);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 9'h084);
        @(posedge clk); #1;
        chk("pre_reset_count", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_reset");
        drive(1'b0, 1'b0, 1'b0, 9'h000);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_idle("after_async");

`ifdef IFQ_STATS_EN
        chk("stats_reset_stall", stall_cycles, 32'd0);
        chk("stats_reset_flush", 32'(flush_count), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 9'(k * 4));
            @(posedge clk); #1;
        end
        chk("stats_full", 32'(pc_write), 32'd0);
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b0, 1'b0, 9'h010);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b1, 9'h000);
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, 9'h000);
        @(posedge clk); #1;
        chk("stats_stall_cycles", stall_cycles, 32'd7);
        chk("stats_flush_count", 32'(flush_count), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
